// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave among NUM_MASTERS masters.
// The owner keeps the bus for its whole cyc; an ack watchdog turns a hung slave into err.
module wb_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [32*NUM_MASTERS-1:0] wbm_adr_i,
    input  logic [32*NUM_MASTERS-1:0] wbm_dat_i,
    input  logic [4*NUM_MASTERS-1:0]  wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    output logic [31:0]               wbm_dat_o,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    output logic [31:0]               wbs_adr_o,
    output logic [31:0]               wbs_dat_o,
    output logic [3:0]                wbs_sel_o,
    output logic                      wbs_we_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    input  logic [31:0]               wbs_dat_i,
    input  logic                      wbs_ack_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam int WD_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_ERR} state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IDX_W-1:0]       owner_q;
    logic [IDX_W-1:0]       ptr_q;
    logic [WD_W-1:0]        wd_q;
    logic [WD_W-1:0]        wd_d;

    logic                   busy;
    logic                   timeout_hit;
    logic                   found;
    logic [IDX_W-1:0]       win_idx;
    logic [NUM_MASTERS-1:0] win_oh;
    logic [IDX_W-1:0]       next_ptr;
    logic                   owner_cyc;
    logic                   owner_stb;
    logic                   owner_we;
    logic [31:0]            owner_adr;
    logic [31:0]            owner_dat;
    logic [3:0]             owner_sel;

    assign busy     = (state_q == S_BUSY);
    assign next_ptr = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        owner_cyc = 1'b0;
        owner_stb = 1'b0;
        owner_we  = 1'b0;
        owner_adr = '0;
        owner_dat = '0;
        owner_sel = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (owner_q == IDX_W'(k)) begin
                owner_cyc = wbm_cyc_i[k];
                owner_stb = wbm_stb_i[k];
                owner_we  = wbm_we_i[k];
                owner_adr = wbm_adr_i[32*k +: 32];
                owner_dat = wbm_dat_i[32*k +: 32];
                owner_sel = wbm_sel_i[4*k +: 4];
            end
        end
    end

    // First pass searches ptr..N-1, second pass wraps around to 0..ptr-1.
    always_comb begin
        found   = 1'b0;
        win_idx = ptr_q;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && IDX_W'(k) >= ptr_q && wbm_cyc_i[k]) begin
                found   = 1'b1;
                win_idx = IDX_W'(k);
            end
        end
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!found && wbm_cyc_i[k]) begin
                found   = 1'b1;
                win_idx = IDX_W'(k);
            end
        end
        win_oh = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            win_oh[k] = (win_idx == IDX_W'(k));
        end
    end

    always_comb begin
        wd_d        = '0;
        timeout_hit = 1'b0;
        if (wbs_stb_o && !wbs_ack_i) begin
            wd_d        = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
            timeout_hit = (TIMEOUT != 0) && (wd_q >= WD_LAST);
        end
    end

    assign wbs_cyc_o = busy & owner_cyc;
    assign wbs_stb_o = busy & owner_cyc & owner_stb;
    assign wbs_we_o  = busy & owner_we;
    assign wbs_adr_o = busy ? owner_adr : '0;
    assign wbs_dat_o = busy ? owner_dat : '0;
    assign wbs_sel_o = busy ? owner_sel : '0;
    assign wbm_dat_o = wbs_dat_i;
    assign wbm_ack_o = grant_q & {NUM_MASTERS{wbs_ack_i & wbs_cyc_o}};
    assign wbm_err_o = grant_q & {NUM_MASTERS{state_q == S_ERR}};
    assign grant_o   = grant_q;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
        end else begin
            wd_q <= wd_d;
            case (state_q)
                S_IDLE: begin
                    if (|wbm_cyc_i) begin
                        grant_q <= win_oh;
                        owner_q <= win_idx;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!owner_cyc) begin
                        grant_q <= '0;
                        ptr_q   <= next_ptr;
                        state_q <= S_IDLE;
                    end else if (timeout_hit) begin
                        state_q <= S_ERR;
                    end
                end
                S_ERR: begin
                    grant_q <= '0;
                    ptr_q   <= next_ptr;
                    state_q <= S_IDLE;
                end
                default: begin
                    grant_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
